// File: rtl/rx_engine.sv
// rtl/rx_engine.sv - UART 8N1 receive engine with oversampled majority-vote bit recovery
module rx_engine #(
    parameter int OSR = 16
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       osr_tick_i,
    input  logic       rx_en_i,
    input  logic       rx_data_i,
    output logic       rx_fifo_wen_o,
    output logic [7:0] rx_fifo_wdata_o,
    output logic       rx_frame_err_o,
    output logic       rx_break_o,
    output logic       rx_busy_o
);

    localparam int TW = $clog2(OSR);
    localparam logic [TW-1:0] T_LAST = TW'(OSR - 1);
    localparam logic [TW-1:0] T_S0   = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OSR / 2);
    localparam logic [TW-1:0] T_S2   = TW'(OSR / 2 + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    samples;
    logic [7:0]    shift_reg;

    logic          sample_hit;
    logic          bit_end;
    logic          stop_eval;
    logic [2:0]    samples_nxt;
    logic          vote;

    // Two-flop synchronizer plus edge register; idle-high reset so no false start
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_data_i;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Mid-bit sampling window and vote; the vote folds in the sample taken this
    // tick so the stop bit can be judged on the third sample itself
    always_comb begin
        sample_hit  = osr_tick_i && ((tick_cnt == T_S0) || (tick_cnt == T_S1) || (tick_cnt == T_S2));
        bit_end     = osr_tick_i && (tick_cnt == T_LAST);
        stop_eval   = osr_tick_i && (tick_cnt == T_S2);
        samples_nxt = sample_hit ? {samples[1:0], rx_s} : samples;
        vote        = (samples_nxt[0] & samples_nxt[1]) |
                      (samples_nxt[0] & samples_nxt[2]) |
                      (samples_nxt[1] & samples_nxt[2]);
    end

    // Frame FSM with registered pulse outputs and busy flag
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state           <= IDLE;
            tick_cnt        <= '0;
            bit_cnt         <= '0;
            samples         <= '0;
            shift_reg       <= '0;
            rx_fifo_wen_o   <= 1'b0;
            rx_fifo_wdata_o <= '0;
            rx_frame_err_o  <= 1'b0;
            rx_break_o      <= 1'b0;
            rx_busy_o       <= 1'b0;
        end else begin
            rx_fifo_wen_o  <= 1'b0;
            rx_frame_err_o <= 1'b0;
            rx_break_o     <= 1'b0;

            if ((state != IDLE) && !rx_en_i) begin
                state     <= IDLE;
                rx_busy_o <= 1'b0;
            end else begin
                if ((state != IDLE) && osr_tick_i) begin
                    samples  <= samples_nxt;
                    tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
                end

                case (state)
                    IDLE: begin
                        if (rx_en_i && rx_prev && !rx_s) begin
                            state     <= START;
                            rx_busy_o <= 1'b1;
                            tick_cnt  <= '0;
                            samples   <= '0;
                        end
                    end
                    START: begin
                        if (bit_end) begin
                            if (!vote) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state     <= IDLE;
                                rx_busy_o <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            shift_reg <= {vote, shift_reg[7:1]};
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        if (stop_eval) begin
                            if (vote) begin
                                rx_fifo_wen_o   <= 1'b1;
                                rx_fifo_wdata_o <= shift_reg;
                            end else begin
                                rx_frame_err_o <= 1'b1;
                                rx_break_o     <= (shift_reg == 8'h00);
                            end
                            state     <= IDLE;
                            rx_busy_o <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        rx_busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_engine.sv
// tb/tb_rx_engine.sv - scoreboard bench for rx_engine
module tb_rx_engine;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       osr_tick;
    logic       rx_en;
    logic       rx_data;
    logic       rx_fifo_wen;
    logic [7:0] rx_fifo_wdata;
    logic       rx_frame_err;
    logic       rx_break;
    logic       rx_busy;
    logic [1:0] div = 2'd0;

    int         vectors    = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic       err_q[$];

    always #5 clk = ~clk;

    // One oversample tick every 4 clocks
    always @(posedge clk) div <= div + 2'd1;
    assign osr_tick = (div == 2'd3);

    rx_engine #(.OSR(16)) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .osr_tick_i     (osr_tick),
        .rx_en_i        (rx_en),
        .rx_data_i      (rx_data),
        .rx_fifo_wen_o  (rx_fifo_wen),
        .rx_fifo_wdata_o(rx_fifo_wdata),
        .rx_frame_err_o (rx_frame_err),
        .rx_break_o     (rx_break),
        .rx_busy_o      (rx_busy)
    );

    // Advance one clock and score any output event against the queues
    task automatic step();
        logic [7:0] e;
        logic       eb;
        @(posedge clk);
        #1;
        if (rx_fifo_wen) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL push_unexpected got=%02h want=none", rx_fifo_wdata);
            end else begin
                e = exp_q.pop_front();
                if (rx_fifo_wdata !== e) begin
                    miscompares++;
                    $display("FAIL push_data got=%02h want=%02h", rx_fifo_wdata, e);
                end
            end
        end
        if (rx_frame_err) begin
            vectors++;
            if (err_q.size() == 0) begin
                miscompares++;
                $display("FAIL frame_err_unexpected got=1 want=0 break=%0b", rx_break);
            end else begin
                eb = err_q.pop_front();
                if (rx_break !== eb) begin
                    miscompares++;
                    $display("FAIL break_flag got=%0b want=%0b", rx_break, eb);
                end
            end
        end
        if (rx_break && !rx_frame_err) begin
            vectors++;
            miscompares++;
            $display("FAIL break_without_frame_err got=1 want=0");
        end
        if (rx_fifo_wen && rx_frame_err) begin
            vectors++;
            miscompares++;
            $display("FAIL push_and_err_together got=1 want=0");
        end
    endtask

    task automatic idle(input int n);
        rx_data = 1'b1;
        repeat (n) step();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (rx_busy && n < 3000) begin
            step();
            n++;
        end
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_timeout got busy=%0b want=0", rx_busy);
        end
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing_push got=%0d pending want=0", name, exp_q.size());
            exp_q.delete();
        end
        vectors++;
        if (err_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing_err got=%0d pending want=0", name, err_q.size());
            err_q.delete();
        end
    endtask

    // act: 0 none, 1 drop enable, 2 assert reset; applied mid-way through frame bit act_bit
    task automatic send_frame(input logic [7:0] data, input logic stop, input int clks,
                              input int act_bit, input int act);
        logic [9:0] bits;
        logic       quit;
        bits = {stop, data, 1'b0};
        quit = 1'b0;
        for (int b = 0; b < 10; b++) begin
            if (!quit) rx_data = bits[b];
            for (int c = 0; c < clks; c++) begin
                if (!quit && b == act_bit && c == clks / 2) begin
                    if (act == 1) begin
                        rx_en = 1'b0;
                        step();
                        step();
                        vectors++;
                        if (rx_busy !== 1'b0) begin
                            miscompares++;
                            $display("FAIL abort_busy got=%0b want=0", rx_busy);
                        end
                    end else if (act == 2) begin
                        reset_n = 1'b0;
                        #1;
                        vectors++;
                        if ({rx_fifo_wen, rx_frame_err, rx_break, rx_busy} !== 4'b0000) begin
                            miscompares++;
                            $display("FAIL midreset_flags got=%04b want=0000",
                                     {rx_fifo_wen, rx_frame_err, rx_break, rx_busy});
                        end
                        vectors++;
                        if (rx_fifo_wdata !== 8'h00) begin
                            miscompares++;
                            $display("FAIL midreset_wdata got=%02h want=00", rx_fifo_wdata);
                        end
                        rx_data = 1'b1;
                        repeat (5) step();
                        reset_n = 1'b1;
                        quit = 1'b1;
                    end
                end
                if (!quit) step();
                if (!quit && b == 0 && c == 10) begin
                    vectors++;
                    if (rx_busy !== 1'b1) begin
                        miscompares++;
                        $display("FAIL start_busy got=%0b want=1", rx_busy);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx_en   = 1'b1;
        rx_data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (rx_fifo_wen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wen got=%0b want=0", rx_fifo_wen);
        end
        vectors++;
        if (rx_fifo_wdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_wdata got=%02h want=00", rx_fifo_wdata);
        end
        vectors++;
        if (rx_frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frame_err got=%0b want=0", rx_frame_err);
        end
        vectors++;
        if (rx_break !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_break got=%0b want=0", rx_break);
        end
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got=%0b want=0", rx_busy);
        end
        reset_n = 1'b1;
        idle(20);
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_busy got=%0b want=0", rx_busy);
        end
    endtask

    task automatic test_good_frame();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 64, -1, 0);
        idle(100);
        wait_idle();
        check_drained("good");
        vectors++;
        if (rx_fifo_wdata !== 8'hA5) begin
            miscompares++;
            $display("FAIL wdata_hold got=%02h want=a5", rx_fifo_wdata);
        end
    endtask

    task automatic test_start_glitch();
        rx_data = 1'b0;
        repeat (12) step();
        rx_data = 1'b1;
        repeat (20) step();
        vectors++;
        if (rx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_busy_start got=%0b want=1", rx_busy);
        end
        repeat (70) step();
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_busy_end got=%0b want=0", rx_busy);
        end
        idle(50);
        check_drained("glitch");
    endtask

    task automatic test_framing_error();
        err_q.push_back(1'b0);
        send_frame(8'h3C, 1'b0, 64, -1, 0);
        rx_data = 1'b0;
        repeat (160) step();
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stuck_low_busy got=%0b want=0", rx_busy);
        end
        idle(64);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 64, -1, 0);
        idle(100);
        wait_idle();
        check_drained("frame_err");
    endtask

    task automatic test_break();
        err_q.push_back(1'b1);
        send_frame(8'h00, 1'b0, 64, -1, 0);
        idle(100);
        wait_idle();
        check_drained("break");
        vectors++;
        if (rx_fifo_wdata !== 8'h11) begin
            miscompares++;
            $display("FAIL break_wdata_hold got=%02h want=11", rx_fifo_wdata);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_frame(8'h55, 1'b1, 66, -1, 0);
        send_frame(8'hAA, 1'b1, 62, -1, 0);
        idle(100);
        wait_idle();
        check_drained("b2b");
    endtask

    task automatic test_abort();
        send_frame(8'hC3, 1'b1, 64, 5, 1);
        idle(20);
        rx_en = 1'b1;
        idle(100);
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle_busy got=%0b want=0", rx_busy);
        end
        check_drained("abort");
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h96, 1'b1, 64, 4, 2);
        idle(50);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 64, -1, 0);
        idle(100);
        wait_idle();
        check_drained("midreset");
        vectors++;
        if (rx_fifo_wdata !== 8'h7E) begin
            miscompares++;
            $display("FAIL midreset_next_frame got=%02h want=7e", rx_fifo_wdata);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_start_glitch();
        test_framing_error();
        test_break();
        test_back_to_back();
        test_abort();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
